// File: rtl/decoder_scan.sv
// -----------------------------------------------------------------------------
// decoder_scan
//   Registered N-to-2^N one-hot decoder with a built-in index sequencer.
//   The index is loaded directly (mode 00), advanced by single-step requests
//   (mode 01), advanced by a free-running prescaled scan (mode 10) or frozen
//   (mode 11). Typical loads: lamp/segment strobes, row scanners, channel
//   enables.
//
// Parameters
//   SEL_W      index width; Y is 2**SEL_W bits wide
//   DIV_W      prescaler width; scan spends div+1 enabled cycles per index
//   ACTIVE_LOW 1 inverts Y (selected line 0, all others 1)
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset, priority over all inputs
//   en      in   enable; low blanks Y and freezes index, prescaler, mode
//   mode    in   00 direct, 01 step, 10 scan, 11 hold
//   sel_in  in   index source in direct mode
//   step    in   advance request in step mode (level, sampled every edge)
//   div     in   scan prescaler terminal count
//   last    in   highest index before wrapping to 0 (step/scan)
//   Y       out  registered decode of idx, gated by registered en
//   idx     out  current index register
//   wrap    out  one-cycle pulse on the edge where idx wraps to 0
// -----------------------------------------------------------------------------
module decoder_scan #(
    parameter int SEL_W      = 3,
    parameter int DIV_W      = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [SEL_W-1:0]     sel_in,
    input  logic                 step,
    input  logic [DIV_W-1:0]     div,
    input  logic [SEL_W-1:0]     last,
    output logic [2**SEL_W-1:0]  Y,
    output logic [SEL_W-1:0]     idx,
    output logic                 wrap
);

    localparam int OUT_W = 2**SEL_W;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_STEP   = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;

    // Idle pattern of Y: all lines inactive.
    localparam logic [OUT_W-1:0] Y_IDLE = {OUT_W{ACTIVE_LOW}};

    logic [SEL_W-1:0] r_idx;
    logic [DIV_W-1:0] r_cnt;
    logic [1:0]       r_prev_mode;
    logic             r_en_q;
    logic             r_wrap;
    logic [OUT_W-1:0] r_y;

    logic [SEL_W-1:0] w_idx_next;
    logic [DIV_W-1:0] w_cnt_next;
    logic [1:0]       w_prev_mode_next;
    logic             w_wrap_next;
    logic [OUT_W-1:0] w_y_next;
    logic [OUT_W-1:0] w_y_onehot;
    logic             w_mode_change;
    logic             w_at_last;
    logic [SEL_W-1:0] w_adv_idx;
    logic             w_adv;
    logic             w_active;

    // Shared advance rule: anything at or beyond 'last' wraps to 0.
    assign w_at_last     = (r_idx >= last);
    assign w_adv_idx     = w_at_last ? '0 : r_idx + SEL_W'(1);
    assign w_mode_change = (mode != r_prev_mode);

    // The first enabled edge after an en=0 stretch only restores Y; it does
    // not load, count or advance, so a frozen sequence resumes exactly where
    // it stopped.
    assign w_active = en && r_en_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_cnt       <= '0;
            r_prev_mode <= MODE_DIRECT;
            r_wrap      <= 1'b0;
            r_en_q      <= 1'b1;
            r_y         <= Y_IDLE;
        end else begin
            r_idx       <= w_idx_next;
            r_cnt       <= w_cnt_next;
            r_prev_mode <= w_prev_mode_next;
            r_wrap      <= w_wrap_next;
            r_en_q      <= en;
            r_y         <= w_y_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_idx_next       = r_idx;
        w_cnt_next       = r_cnt;
        w_prev_mode_next = r_prev_mode;
        w_wrap_next      = 1'b0;
        w_adv            = 1'b0;
        if (w_active) begin
            w_prev_mode_next = mode;
            case (mode)
                MODE_DIRECT: begin
                    w_idx_next = sel_in;
                    w_cnt_next = '0;
                end
                MODE_STEP: begin
                    w_cnt_next = '0;
                    w_adv      = step;
                end
                MODE_SCAN: begin
                    // Entry edge clears the prescaler without counting, so the
                    // first advance lands div+1 enabled edges after entry.
                    if (w_mode_change) begin
                        w_cnt_next = '0;
                    end else if (r_cnt == div) begin
                        w_adv      = 1'b1;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    if (w_mode_change) begin
                        w_cnt_next = '0;
                    end
                end
            endcase
            if (w_adv) begin
                w_idx_next  = w_adv_idx;
                w_wrap_next = w_at_last;
            end
        end
    end

    // Output logic: Y is decoded from the next index so that Y and idx
    // always change on the same edge.
    always_comb begin
        w_y_onehot = OUT_W'(1) << w_idx_next;
        if (!en) begin
            w_y_onehot = '0;
        end
        w_y_next = ACTIVE_LOW ? ~w_y_onehot : w_y_onehot;
    end

    assign Y    = r_y;
    assign idx  = r_idx;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan
//   Bench for decoder_scan. A main instance (SEL_W=3, active-high) is checked
//   every cycle against a behavioural model; a second instance (SEL_W=4,
//   ACTIVE_LOW=1) is checked with literal values.
// -----------------------------------------------------------------------------
module tb_decoder_scan;

    localparam int SEL_W = 3;
    localparam int DIV_W = 8;
    localparam int OUT_W = 8;
    localparam int EXP_W = OUT_W + SEL_W + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic [SEL_W-1:0] sel_in;
    logic             step;
    logic [DIV_W-1:0] div;
    logic [SEL_W-1:0] last;
    logic [OUT_W-1:0] y;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    logic [3:0]       al_sel;
    logic [3:0]       al_last;
    logic [15:0]      al_y;
    logic [3:0]       al_idx;
    logic             al_wrap;

    int n_vec = 0;
    int n_bad = 0;

    decoder_scan #(.SEL_W(SEL_W), .DIV_W(DIV_W), .ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
        .step(step), .div(div), .last(last),
        .Y(y), .idx(idx), .wrap(wrap)
    );

    decoder_scan #(.SEL_W(4), .DIV_W(DIV_W), .ACTIVE_LOW(1'b1)) u_dut_al (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(al_sel),
        .step(step), .div(div), .last(al_last),
        .Y(al_y), .idx(al_idx), .wrap(al_wrap)
    );

    // ---------------- behavioural model ----------------
    // Expected {Y, idx, wrap} after each edge, queued for the compare process.
    logic [EXP_W-1:0] exp_q[$];

    int m_idx;
    int m_cnt;
    int m_prev_mode;
    bit m_en_last;
    bit m_y_on;
    bit m_wrap;
    bit m_changed;
    logic [OUT_W-1:0] m_y;

    function automatic void m_advance();
        if (m_idx >= int'(last)) begin
            m_idx  = 0;
            m_wrap = 1'b1;
        end else begin
            m_idx = m_idx + 1;
        end
    endfunction

    always @(posedge clk) begin
        m_wrap = 1'b0;
        if (rst) begin
            m_idx       = 0;
            m_cnt       = 0;
            m_prev_mode = 0;
            m_en_last   = 1'b1;
            m_y_on      = 1'b0;
        end else if (!en) begin
            m_en_last = 1'b0;
            m_y_on    = 1'b0;
        end else if (!m_en_last) begin
            m_en_last = 1'b1;
            m_y_on    = 1'b1;
        end else begin
            m_y_on      = 1'b1;
            m_changed   = (int'(mode) != m_prev_mode);
            m_prev_mode = int'(mode);
            if (m_changed) m_cnt = 0;
            case (int'(mode))
                0: begin
                    m_idx = int'(sel_in);
                    m_cnt = 0;
                end
                1: begin
                    m_cnt = 0;
                    if (step) m_advance();
                end
                2: begin
                    if (!m_changed) begin
                        if (m_cnt == int'(div)) begin
                            m_advance();
                            m_cnt = 0;
                        end else begin
                            m_cnt = (m_cnt + 1) % 256;
                        end
                    end
                end
                default: ;
            endcase
        end
        m_y = m_y_on ? 8'(1 << m_idx) : 8'h00;
        exp_q.push_back({m_y, 3'(m_idx), m_wrap});
    end

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] cmp_e;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            n_vec++;
            if ({y, idx, wrap} !== cmp_e) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t got Y=%h idx=%0d wrap=%b expected Y=%h idx=%0d wrap=%b",
                         $time, y, idx, wrap, cmp_e[EXP_W-1:SEL_W+1], cmp_e[SEL_W:1], cmp_e[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    int exp_i;

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; sel_in = '0; step = 1'b0;
        div = '0; last = 3'd7; al_sel = 4'd9; al_last = 4'd15;

        // Reset / direct
        cyc(2);
        chk("rst_y", 32'(y), 32'h00);
        chk("rst_idx", 32'(idx), 0);
        chk("rst_al_y", 32'(al_y), 32'hFFFF);
        rst = 1'b0; en = 1'b1; sel_in = 3'd5;
        cyc(1);
        chk("direct_y", 32'(y), 32'h20);
        chk("direct_idx", 32'(idx), 5);
        chk("al_direct_y", 32'(al_y), 32'hFDFF);
        en = 1'b0;
        cyc(1);
        chk("dis_y", 32'(y), 32'h00);
        chk("dis_idx", 32'(idx), 5);
        chk("al_dis_y", 32'(al_y), 32'hFFFF);

        // Re-enable restores Y without loading, then direct load of 0
        en = 1'b1; sel_in = 3'd0;
        cyc(1);
        chk("resume_y", 32'(y), 32'h20);
        chk("resume_idx", 32'(idx), 5);
        cyc(1);
        chk("load0_idx", 32'(idx), 0);

        // Scan wrap: div=2, last=3
        mode = 2'b10; div = 8'd2; last = 3'd3;
        for (int k = 0; k < 15; k++) begin
            cyc(1);
            exp_i = (k / 3) % 4;
            chk("scan_idx", 32'(idx), 32'(exp_i));
            chk("scan_y", 32'(y), 32'(1 << exp_i));
            chk("scan_wrap", 32'(wrap), (k == 12) ? 32'd1 : 32'd0);
        end

        // Step with overshoot
        mode = 2'b00; sel_in = 3'd6;
        cyc(1);
        chk("ovs_load", 32'(idx), 6);
        mode = 2'b01; last = 3'd3; step = 1'b1;
        cyc(1);
        chk("ovs_idx", 32'(idx), 0);
        chk("ovs_wrap", 32'(wrap), 1);
        step = 1'b0;
        cyc(1);
        chk("step_idle_wrap", 32'(wrap), 0);
        step = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("step_idx", 32'(idx), 32'((k + 1) % 4));
            chk("step_wrap", 32'(wrap), (k == 3) ? 32'd1 : 32'd0);
        end

        // last=0 pins idx at 0 with wrap on every advance
        last = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("last0_idx", 32'(idx), 0);
            chk("last0_wrap", 32'(wrap), 1);
        end
        step = 1'b0; last = 3'd7;

        // Hold freeze: scan div=4, hold 10 cycles, back to scan
        mode = 2'b10; div = 8'd4;
        for (int k = 0; k < 7; k++) begin
            cyc(1);
            chk("scan4_idx", 32'(idx), (k >= 5) ? 32'd1 : 32'd0);
        end
        mode = 2'b11;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            chk("hold_idx", 32'(idx), 1);
            chk("hold_y", 32'(y), 32'h02);
        end
        mode = 2'b10;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            chk("reentry_idx", 32'(idx), (k == 5) ? 32'd2 : 32'd1);
        end

        // Enable freeze: cnt=2 when en drops, advance 3 edges after resume edge
        cyc(2);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            chk("enfrz_y", 32'(y), 32'h00);
            chk("enfrz_idx", 32'(idx), 2);
        end
        en = 1'b1;
        cyc(1);
        chk("enres_y", 32'(y), 32'h04);
        chk("enres_idx", 32'(idx), 2);
        cyc(2);
        chk("enres_hold_idx", 32'(idx), 2);
        cyc(1);
        chk("enres_adv_idx", 32'(idx), 3);
        chk("enres_adv_y", 32'(y), 32'h08);

        // Reset mid-scan
        mode = 2'b00; sel_in = 3'd2;
        cyc(1);
        mode = 2'b10; div = 8'd4;
        cyc(3);
        chk("mid_idx", 32'(idx), 2);
        rst = 1'b1;
        cyc(1);
        chk("midrst_idx", 32'(idx), 0);
        chk("midrst_wrap", 32'(wrap), 0);
        chk("midrst_y", 32'(y), 32'h00);
        chk("midrst_al_y", 32'(al_y), 32'hFFFF);
        rst = 1'b0; div = 8'd1;
        cyc(2);
        chk("post_rst_idx", 32'(idx), 0);
        cyc(1);
        chk("post_rst_adv", 32'(idx), 1);
        chk("post_rst_y", 32'(y), 32'h02);

        // Randomized phase, checked by the model
        for (int blk = 0; blk < 300; blk++) begin
            mode   = 2'($urandom_range(0, 3));
            en     = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 39) == 0);
            sel_in = 3'($urandom_range(0, 7));
            last   = 3'($urandom_range(0, 7));
            if (mode == 2'b11) div = 8'($urandom_range(0, 3));
            repeat ($urandom_range(1, 8)) begin
                step = 1'($urandom_range(0, 1));
                cyc(1);
            end
        end
        rst = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with a built-in index sequencer.
- The decoded index comes from one of three sources: a direct select input, single-step pulses, or free-running scan with a programmable prescaler and wrap point.
- Drives multiplexed outputs such as lamp/segment strobes, row scanners and channel enables, replacing hand-written fixed-width combinational decoders.

Parameters:
- SEL_W, 3, index width; output width is 2**SEL_W.
- DIV_W, 8, prescaler width; scan period is div+1 cycles per index.
- ACTIVE_LOW, 0, if 1 the output Y is inverted: selected line 0, others 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  enable; low forces Y inactive and freezes the index and prescaler.
- mode  input  2  00 direct, 01 step, 10 scan, 11 hold.
- sel_in  input  SEL_W  index source in direct mode.
- step  input  1  advance request in step mode, sampled each cycle.
- div  input  DIV_W  scan prescaler terminal count.
- last  input  SEL_W  highest index before wrap to 0 (step and scan modes).
- Y  output  2**SEL_W  registered one-hot decode of idx; Y[k] is active when idx==k and en==1.
- idx  output  SEL_W  current index register.
- wrap  output  1  one-cycle pulse on the edge where idx advances from >=last to 0.

Behaviour:
- Reset (rst=1 at an edge) has priority over all inputs:
  - idx=0, prescaler cnt=0, stored previous mode=00, wrap=0.
  - Y=all inactive: all 0, or all 1 if ACTIVE_LOW.
  - Reset mid-scan abandons the sequence; the first post-reset advance goes to idx=1.
- Y and idx are both registers updated on the same edge, so Y always equals decode(idx) gated by the registered en. There is no combinational path from any input to Y.
- Advance rule, shared by step and scan:
  - If idx>=last, idx_next=0 and wrap=1 for that cycle; otherwise idx_next=idx+1 and wrap=0.
  - last=0 pins idx at 0 with wrap pulsing on every advance.
  - idx>last (e.g. left over from direct mode) wraps to 0 on the next advance.
  - A change to last takes effect at the next advance; there is no retroactive jump.
- en=0: idx, cnt and the stored mode hold; Y=inactive from the next edge; wrap=0. Returning to en=1 restores Y=decode(idx) after one edge with no advance on that edge.
- Direct (00): idx<=sel_in every enabled edge; latency is 1 cycle from sel_in to Y. wrap is always 0 and cnt is held at 0.
- Step (01): each enabled edge with step=1 performs one advance. step held high advances every cycle; there is no edge detection. cnt is held at 0.
- Scan (10): cnt increments each enabled edge.
  - When cnt==div: advance and set cnt=0.
  - The first advance after entering scan occurs div+1 enabled cycles after entry.
  - div=0 advances every cycle.
  - A div change mid-count: if the new div<cnt, cnt keeps counting and wraps modulo 2**DIV_W. The bench treats this as legal but undefined-period; software changes div only in hold.
- Hold (11): idx, cnt and Y frozen (Y still decoded while en=1); wrap=0.
- Mode change: on the edge where mode differs from the stored previous mode, cnt<=0 and the new mode's action applies on that same edge. A direct load or step advance happens immediately; scan begins counting from 0.
- Outputs never show more than one active line. Every unused code point is impossible, because idx is full-range SEL_W.

Test Plan:
- Reset/direct:
  - Stimulus: rst high 2 cycles, then mode=00, en=1, sel_in=5 (SEL_W=3).
  - Required: Y=8'h00 and idx=0 during reset; one edge after sel_in=5, Y=8'h20, idx=5.
  - Then en=0: Y=8'h00 next edge with idx still 5.
- Scan wrap:
  - Stimulus: mode=10, div=2, last=3, from idx=0.
  - Required: idx sequence 0,1,2,3,0 changes every 3 cycles.
  - Required: wrap high exactly on the 3->0 edge; Y cycles 01,02,04,08,01.
- Step with overshoot:
  - Stimulus: direct load idx=6, then mode=01, last=3, one-cycle step pulse.
  - Required: idx=0, wrap=1 on that edge.
  - Then step held 4 cycles: idx 1,2,3,0 with wrap on the last edge.
- Hold and enable freeze:
  - Stimulus: scanning with div=4, switch to mode=11 for 10 cycles, then back to 10.
  - Required: idx unchanged during hold.
  - Required: after re-entry the next advance occurs 5 cycles later, because cnt cleared on the mode change.
  - Repeat with en=0 instead of hold: Y=0 throughout, idx/cnt preserved, no advance.
- ACTIVE_LOW=1, SEL_W=4:
  - Stimulus: direct sel_in=9.
  - Required: Y=16'hFDFF; with en=0, Y=16'hFFFF; in reset, Y=16'hFFFF.
- Reset mid-scan:
  - Stimulus: rst asserted one cycle at idx=2 with cnt mid-count.
  - Required: idx=0, wrap=0, Y inactive on the reset edge.
  - Required: after release in scan mode with div=1, the first advance to idx=1 occurs 2 cycles later.
